// File: rtl/axis_packet_capture_pkg.sv
// axis_pkt_pkg: shared constants, FSM state type and tkeep helpers for the
// AXI4-Stream packet capture block.
//   DATA_W / KEEP_W : stream data and byte-enable widths
//   MAX_FLITS       : flit buffer depth (longest packet stored)
//   CNT_W           : flit count / buffer address width
package axis_pkt_pkg;

    localparam int DATA_W    = 64;
    localparam int KEEP_W    = DATA_W / 8;
    localparam int MAX_FLITS = 23;
    localparam int CNT_W     = 5;
    localparam int POP_W     = $clog2(KEEP_W + 1);

    typedef enum logic [1:0] {
        RECV = 2'd0,
        DROP = 2'd1,
        DONE = 2'd2
    } cap_state_t;

    // Number of valid bytes in a flit.
    function automatic logic [POP_W-1:0] keep_popcount(input logic [KEEP_W-1:0] keep);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            n = n + POP_W'(keep[i]);
        end
        return n;
    endfunction

    // Non-last flits must be full; the last flit must be a nonzero run of
    // ones starting at byte 0 (keep+1 is then a power of two).
    function automatic logic keep_is_legal(input logic [KEEP_W-1:0] keep, input logic last);
        logic [KEEP_W-1:0] nxt;
        nxt = keep + KEEP_W'(1);
        if (!last) begin
            return keep == '1;
        end
        return (keep != '0) && ((keep & nxt) == '0);
    endfunction

endpackage

// File: rtl/axis_packet_capture_if.sv
// axis_packet_capture_if: AXI4-Stream flit bus (tdata/tkeep/tlast/tvalid/tready).
//   master : drives data, keep, last, valid; samples ready
//   slave  : samples data, keep, last, valid; drives ready
interface axis_packet_capture_if;
    import axis_pkt_pkg::*;

    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, tkeep, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tvalid, output tready);

endinterface

// File: rtl/axis_flit_buffer.sv
// axis_flit_buffer: simple dual-port RAM, MAX_FLITS words of {tkeep, tdata}.
//   clk     : clock
//   wr_en   : write wr_word at wr_addr
//   rd_addr : read address; rd_word follows one cycle later
//   rd_word : registered read data (holds when rd_addr is past the end)
module axis_flit_buffer
    import axis_pkt_pkg::*;
(
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [CNT_W-1:0]         wr_addr,
    input  logic [DATA_W+KEEP_W-1:0] wr_word,
    input  logic [CNT_W-1:0]         rd_addr,
    output logic [DATA_W+KEEP_W-1:0] rd_word
);

    logic [DATA_W+KEEP_W-1:0] mem [MAX_FLITS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_word;
        end
        // Addresses beyond the array are masked to zero by the caller anyway.
        if (rd_addr < CNT_W'(MAX_FLITS)) begin
            rd_word <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/axis_packet_capture.sv
// axis_packet_capture: AXI4-Stream sink that stores one packet, checks tkeep
// and hands a descriptor plus random-access read port to a consumer.
//   CLK, RESET        : clock, synchronous active-high reset
//   S_AXIS            : incoming flit stream (slave side)
//   pkt_valid/ready   : descriptor handshake; ready releases the packet
//   pkt_num_flits     : flits stored
//   pkt_num_bytes     : sum of popcount(tkeep) over stored flits
//   pkt_err_overflow  : packet longer than MAX_FLITS, tail dropped
//   pkt_err_keep      : illegal tkeep seen in the packet
//   pkt_count         : packets released since reset (wraps)
//   rd_addr/data/keep : buffer read, 1-cycle latency, zero past pkt_num_flits
module axis_packet_capture
    import axis_pkt_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RESET,
    axis_packet_capture_if.slave  S_AXIS,
    output logic                  pkt_valid,
    input  logic                  pkt_ready,
    output logic [CNT_W-1:0]      pkt_num_flits,
    output logic [7:0]            pkt_num_bytes,
    output logic                  pkt_err_overflow,
    output logic                  pkt_err_keep,
    output logic [31:0]           pkt_count,
    input  logic [CNT_W-1:0]      rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic [KEEP_W-1:0]     rd_keep
);

    cap_state_t               state;
    logic                     ready;
    logic                     xfer;
    logic                     release_hs;
    logic                     rd_hit;
    logic [31:0]              done_count;
    logic [DATA_W+KEEP_W-1:0] rd_word;

    assign S_AXIS.tready = ready;
    assign xfer          = S_AXIS.tvalid && ready;
    assign release_hs    = (state == DONE) && pkt_ready;
    assign pkt_count     = done_count;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state            <= RECV;
            ready            <= 1'b1;
            pkt_valid        <= 1'b0;
            pkt_num_flits    <= '0;
            pkt_num_bytes    <= '0;
            pkt_err_overflow <= 1'b0;
            pkt_err_keep     <= 1'b0;
        end else begin
            unique case (state)
                RECV: begin
                    if (xfer) begin
                        pkt_num_flits <= pkt_num_flits + CNT_W'(1);
                        pkt_num_bytes <= pkt_num_bytes + 8'(keep_popcount(S_AXIS.tkeep));
                        if (!keep_is_legal(S_AXIS.tkeep, S_AXIS.tlast)) begin
                            pkt_err_keep <= 1'b1;
                        end
                        if (S_AXIS.tlast) begin
                            state     <= DONE;
                            ready     <= 1'b0;
                            pkt_valid <= 1'b1;
                        end else if (pkt_num_flits == CNT_W'(MAX_FLITS - 1)) begin
                            state <= DROP;
                        end
                    end
                end
                DROP: begin
                    // Tail flits are swallowed but still keep-checked.
                    if (xfer) begin
                        if (!keep_is_legal(S_AXIS.tkeep, S_AXIS.tlast)) begin
                            pkt_err_keep <= 1'b1;
                        end
                        if (S_AXIS.tlast) begin
                            state            <= DONE;
                            ready            <= 1'b0;
                            pkt_valid        <= 1'b1;
                            pkt_err_overflow <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (pkt_ready) begin
                        state            <= RECV;
                        ready            <= 1'b1;
                        pkt_valid        <= 1'b0;
                        pkt_num_flits    <= '0;
                        pkt_num_bytes    <= '0;
                        pkt_err_overflow <= 1'b0;
                        pkt_err_keep     <= 1'b0;
                    end
                end
                default: begin
                    state <= RECV;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    // Written every cycle so the counter always reflects its own current value.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            done_count <= '0;
        end else begin
            done_count <= done_count + 32'(release_hs);
        end
    end

    // Range check is taken with the same edge that samples the RAM, so the
    // zero mask lines up with the registered read word.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_hit <= 1'b0;
        end else begin
            rd_hit <= (rd_addr < pkt_num_flits);
        end
    end

    assign rd_data = rd_hit ? rd_word[DATA_W-1:0] : '0;
    assign rd_keep = rd_hit ? rd_word[DATA_W+KEEP_W-1:DATA_W] : '0;

    axis_flit_buffer u_buf (
        .clk     (CLK),
        .wr_en   (xfer && (state == RECV)),
        .wr_addr (pkt_num_flits),
        .wr_word ({S_AXIS.tkeep, S_AXIS.tdata}),
        .rd_addr (rd_addr),
        .rd_word (rd_word)
    );

endmodule

// File: tb/tb_axis_packet_capture.sv
// tb_axis_packet_capture: directed bench for axis_packet_capture.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_axis_packet_capture;
    import axis_pkt_pkg::*;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic              pkt_valid;
    logic              pkt_ready = 1'b0;
    logic [CNT_W-1:0]  pkt_num_flits;
    logic [7:0]        pkt_num_bytes;
    logic              pkt_err_overflow;
    logic              pkt_err_keep;
    logic [31:0]       pkt_count;
    logic [CNT_W-1:0]  rd_addr = '0;
    logic [DATA_W-1:0] rd_data;
    logic [KEEP_W-1:0] rd_keep;

    int n_cmp = 0;
    int n_bad = 0;
    int hs_cnt = 0;

    axis_packet_capture_if s_axis ();

    axis_packet_capture dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .S_AXIS           (s_axis),
        .pkt_valid        (pkt_valid),
        .pkt_ready        (pkt_ready),
        .pkt_num_flits    (pkt_num_flits),
        .pkt_num_bytes    (pkt_num_bytes),
        .pkt_err_overflow (pkt_err_overflow),
        .pkt_err_keep     (pkt_err_keep),
        .pkt_count        (pkt_count),
        .rd_addr          (rd_addr),
        .rd_data          (rd_data),
        .rd_keep          (rd_keep)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (s_axis.tvalid && s_axis.tready) hs_cnt <= hs_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        s_axis.tvalid = 1'b0;
        pkt_ready = 1'b0;
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
    endtask

    // Called on a falling edge; returns on the falling edge after the transfer.
    task automatic push(input logic [63:0] d, input logic [7:0] k, input logic l);
        int n;
        n = 0;
        s_axis.tdata  = d;
        s_axis.tkeep  = k;
        s_axis.tlast  = l;
        s_axis.tvalid = 1'b1;
        while (!s_axis.tready && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("push_tready", 64'(s_axis.tready), 64'd1);
        @(negedge CLK);
        s_axis.tvalid = 1'b0;
    endtask

    task automatic desc(input string tag, input int fl, input int by, input logic ov, input logic ke);
        chk({tag, "_valid"}, 64'(pkt_valid), 64'd1);
        chk({tag, "_flits"}, 64'(pkt_num_flits), 64'(fl));
        chk({tag, "_bytes"}, 64'(pkt_num_bytes), 64'(by));
        chk({tag, "_ovf"}, 64'(pkt_err_overflow), 64'(ov));
        chk({tag, "_kerr"}, 64'(pkt_err_keep), 64'(ke));
    endtask

    task automatic rd(input string tag, input int a, input logic [63:0] d, input logic [7:0] k);
        rd_addr = CNT_W'(a);
        @(negedge CLK);
        chk({tag, "_data"}, rd_data, d);
        chk({tag, "_keep"}, 64'(rd_keep), 64'(k));
    endtask

    task automatic release_pkt(input string tag, input logic [31:0] cnt);
        pkt_ready = 1'b1;
        @(negedge CLK);
        pkt_ready = 1'b0;
        chk({tag, "_rel_tready"}, 64'(s_axis.tready), 64'd1);
        chk({tag, "_rel_valid"}, 64'(pkt_valid), 64'd0);
        chk({tag, "_count"}, 64'(pkt_count), 64'(cnt));
    endtask

    initial begin
        int hs0;
        s_axis.tdata  = '0;
        s_axis.tkeep  = '0;
        s_axis.tlast  = 1'b0;
        s_axis.tvalid = 1'b0;

        // Reset state
        do_reset();
        chk("rst_tready", 64'(s_axis.tready), 64'd1);
        chk("rst_valid", 64'(pkt_valid), 64'd0);
        chk("rst_flits", 64'(pkt_num_flits), 64'd0);
        chk("rst_bytes", 64'(pkt_num_bytes), 64'd0);
        chk("rst_ovf", 64'(pkt_err_overflow), 64'd0);
        chk("rst_kerr", 64'(pkt_err_keep), 64'd0);
        chk("rst_count", 64'(pkt_count), 64'd0);
        chk("rst_rdata", rd_data, 64'd0);
        chk("rst_rkeep", 64'(rd_keep), 64'd0);

        // Nominal 4-flit packet
        push(64'h1122334455667788, 8'hff, 1'b0);
        push(64'h0000007447c0887a, 8'hff, 1'b0);
        push(64'h0100000100030000, 8'hff, 1'b0);
        chk("nom_prevalid", 64'(pkt_valid), 64'd0);
        push(64'h5073930200000000, 8'h0f, 1'b1);
        desc("nom", 4, 28, 1'b0, 1'b0);
        chk("nom_tready", 64'(s_axis.tready), 64'd0);
        rd("nom_rd3", 3, 64'h5073930200000000, 8'h0f);
        rd("nom_rd0", 0, 64'h1122334455667788, 8'hff);
        rd("nom_rd4", 4, 64'd0, 8'h00);
        release_pkt("nom", 32'd1);

        // Backpressure with a second packet offered
        do_reset();
        push(64'hAAAA000000000001, 8'hff, 1'b0);
        push(64'hAAAA000000000002, 8'h03, 1'b1);
        desc("bpA", 2, 10, 1'b0, 1'b0);
        hs0 = hs_cnt;
        s_axis.tdata  = 64'hBBBB000000000000;
        s_axis.tkeep  = 8'hff;
        s_axis.tlast  = 1'b0;
        s_axis.tvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk("bp_tready", 64'(s_axis.tready), 64'd0);
        end
        chk("bp_no_hs", 64'(hs_cnt), 64'(hs0));
        desc("bpA_hold", 2, 10, 1'b0, 1'b0);
        release_pkt("bpA", 32'd1);
        push(64'hBBBB000000000000, 8'hff, 1'b0);
        push(64'hBBBB000000000001, 8'hff, 1'b0);
        push(64'hBBBB000000000002, 8'h01, 1'b1);
        desc("bpB", 3, 17, 1'b0, 1'b0);
        rd("bpB_rd0", 0, 64'hBBBB000000000000, 8'hff);
        rd("bpB_rd2", 2, 64'hBBBB000000000002, 8'h01);
        release_pkt("bpB", 32'd2);

        // Overflow: 25 full flits
        hs0 = hs_cnt;
        for (int i = 0; i < 25; i++) begin
            push(64'hD000000000000000 + 64'(i), 8'hff, (i == 24));
        end
        chk("ovf_hs", 64'(hs_cnt - hs0), 64'd25);
        desc("ovf", 23, 184, 1'b1, 1'b0);
        rd("ovf_rd22", 22, 64'hD000000000000016, 8'hff);
        rd("ovf_rd23", 23, 64'd0, 8'h00);
        release_pkt("ovf", 32'd3);

        // Keep error in a middle flit
        push(64'h1, 8'hff, 1'b0);
        push(64'h2, 8'h7f, 1'b0);
        push(64'h3, 8'hff, 1'b0);
        push(64'h4, 8'hff, 1'b1);
        desc("kmid", 4, 31, 1'b0, 1'b1);
        release_pkt("kmid", 32'd4);

        // Single empty last flit
        push(64'h5, 8'h00, 1'b1);
        desc("kzero", 1, 0, 1'b0, 1'b1);
        release_pkt("kzero", 32'd5);

        // Reset in the middle of a packet
        push(64'h6, 8'hff, 1'b0);
        push(64'h7, 8'hff, 1'b0);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        chk("mrst_valid", 64'(pkt_valid), 64'd0);
        chk("mrst_tready", 64'(s_axis.tready), 64'd1);
        chk("mrst_flits", 64'(pkt_num_flits), 64'd0);
        push(64'h00000000000000EE, 8'h01, 1'b1);
        desc("mrst", 1, 1, 1'b0, 1'b0);
        rd("mrst_rd0", 0, 64'h00000000000000EE, 8'h01);
        release_pkt("mrst", 32'd1);

        // Packet counter wrap
        force dut.done_count = 32'hffffffff;
        repeat (2) @(negedge CLK);
        release dut.done_count;
        @(negedge CLK);
        chk("wrap_pre", 64'(pkt_count), 64'hffffffff);
        push(64'h9, 8'hff, 1'b1);
        desc("wrap", 1, 8, 1'b0, 1'b0);
        release_pkt("wrap", 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
